unidade_load_store: RTL
=======================

Name: unidade_load_store

Overview:
Initiator side of the data-memory interface. Sits between the CPU datapath (MEM stage) and memoria_de_dados, and translates byte-addressed MIPS loads and stores (lb/lbu/lh/lhu/lw/sb/sh/sw) into word accesses on the word-indexed memory. The memory only has a word write enable, so sub-word stores are done as a read-modify-write sequence. Misaligned and out-of-range accesses are reported as faults, and memory is not touched for them.

Parameters:
MEM_WORDS, 500, number of 32-bit words in the attached data memory; word address must be < MEM_WORDS.
ADDR_W, 32, width of the byte address and of mem_addr.

Ports:
clk  input  1  clock; all state updates on posedge.
rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
req_valid  input  1  CPU request strobe.
req_ready  output  1  high only in IDLE; a request is accepted on a posedge where req_valid && req_ready.
req_we  input  1  1 = store, 0 = load.
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_addr  input  ADDR_W  byte address.
req_wdata  input  32  store data; the value is right-aligned (byte in [7:0], half in [15:0]).
resp_valid  output  1  one-cycle pulse when the access completes.
resp_rdata  output  32  extended load data; 0 for stores and faults.
resp_fault  output  1  valid with resp_valid; 1 = misaligned, illegal size, or out of range.
mem_we  output  1  to the memory write enable.
mem_addr  output  ADDR_W  word address (req_addr >> 2).
mem_wdata  output  32  to the memory data-in.
mem_rdata  input  32  from the memory data-out. The memory updates it on negedge from mem_addr, so it is valid at the next posedge.

Behaviour:
- Reset (rst_n=0 at posedge): state goes to IDLE. resp_valid=0, resp_rdata=0, resp_fault=0, mem_we=0, mem_addr=0, mem_wdata=0. All outputs are registered or decoded from state only.
- Byte lanes are big-endian. Offset 0 maps to [31:24], offset 3 to [7:0]. Halfword offset 0 maps to [31:16], offset 2 to [15:0].
- Fault check at accept time:
  - size 11 is a fault.
  - halfword with addr[0]=1 is a fault.
  - word with addr[1:0]≠0 is a fault.
  - (addr>>2) ≥ MEM_WORDS is a fault.
- States:
  - IDLE: req_ready=1. On accept, latch the request and drive mem_addr=addr>>2. Next state is RESP(fault) if the fault check fails, WR for a word store, and RD otherwise.
  - RD: mem_we=0. At the posedge leaving RD, capture mem_rdata. For a load, extract and extend the selected lane into resp_rdata, then go to RESP. For a sub-word store, merge req_wdata into the selected lane of the captured word into mem_wdata, then go to WR.
  - WR: mem_we=1 for exactly one cycle. The memory commits on the posedge leaving WR. Then go to RESP.
  - RESP: resp_valid=1 for one cycle, with resp_fault and resp_rdata valid. Then go to IDLE.
- Latency, counted in cycles from the accept edge to the resp_valid cycle:
  - fault: 1
  - load: 2
  - word store: 2
  - sub-word store: 3
- Throughput: one request in flight. req_ready=0 in RD, WR and RESP, so back-to-back requests are accepted one cycle after resp_valid.
- Sign extension: lb/lh replicate bit 7/15 of the selected lane; lbu/lhu zero-fill.
- req_unsigned and req_wdata are ignored where they do not apply. req_wdata upper bits beyond the size are ignored.
- A fault never asserts mem_we. mem_addr may still change for a fault, which is harmless because no write occurs.
- Reset mid-operation: the sequence is aborted and no resp_valid is issued. If rst_n=0 coincides with the posedge leaving WR, the memory write on that edge still completes, since the memory has no reset. An RMW aborted in RD writes nothing.
- Request inputs only need to be stable at the accept edge; they are latched.

Decomposition:
- Shared package (pkg_lsu): size encodings (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10), the state encoding (IDLE, RD, WR, RESP), and the MEM_WORDS default.
- One combinational sub-module, lsu_alinhador_bytes. Inputs: word, offset, size, unsigned, store data. Outputs: the extended load value and the merged store word. The FSM stays in unidade_load_store.

Test Plan:
- Preload mem[3]=0x11223344. lb 0x0D, then lbu 0x0F, then lh 0x0E → resp_rdata 0x00000022, 0x00000044, 0x00003344. Each resp_valid comes 2 cycles after accept, with fault=0.
- Preload mem[4]=0x80FF7F01. lb 0x11 → 0xFFFFFFFF; lbu 0x11 → 0x000000FF; lh 0x10 → 0xFFFF80FF; lhu 0x10 → 0x000080FF.
- Preload mem[3]=0x11223344, then sb 0x0E with wdata 0xDEADBEAB → mem[3]=0x1122AB44. mem_we is high for exactly one cycle, resp_valid arrives 3 cycles after accept, then lw 0x0C returns 0x1122AB44.
- sw 0x20 with wdata 0xCAFEBABE → mem[8]=0xCAFEBABE after 2 cycles. sh 0x22 with wdata 0x1234 → mem[8]=0xCAFE1234.
- Faults, each giving resp_fault=1, resp_rdata=0, mem_we=0 throughout, resp 1 cycle after accept:
  - lw 0x06
  - lh 0x03
  - size 11
  - sw 0x7D0 (word 500)
- Reset: assert rst_n=0 for one edge while in RD of an sb → no resp_valid and memory unchanged. Then state is IDLE with req_ready=1, all other outputs 0, and the next lw completes normally.

Source files
------------

// File: rtl/pkg_lsu.sv
// Shared definitions for the load/store unit.
//   - Access size encodings carried on req_size.
//   - FSM state encoding used by unidade_load_store.
//   - Default size of the attached data memory, in 32-bit words.
package pkg_lsu;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam int MEM_WORDS_DEF = 500;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } lsu_state_t;

endpackage

// File: rtl/lsu_alinhador_bytes.sv
// Big-endian byte-lane aligner (purely combinational).
// Ports:
//   i_word     : 32-bit word read from memory
//   i_offset   : byte offset inside the word (addr[1:0])
//   i_size     : access size (byte / half / word)
//   i_unsigned : 1 = zero-extend loads, 0 = sign-extend
//   i_wdata    : right-aligned store data
//   o_load     : selected lane, extended to 32 bits
//   o_store    : i_word with the store data merged into the selected lane
module lsu_alinhador_bytes
    import pkg_lsu::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_store
);

    // Offset 0 is the most significant lane: byte shift = (3-off)*8,
    // which for a 2-bit offset is simply ~off * 8. Halfwords use off[1].
    logic [4:0]  w_sh_b;
    logic [4:0]  w_sh_h;
    logic [31:0] w_word_b;
    logic [31:0] w_word_h;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_sh_b   = {~i_offset, 3'b000};
    assign w_sh_h   = {~i_offset[1], 4'b0000};
    assign w_word_b = i_word >> w_sh_b;
    assign w_word_h = i_word >> w_sh_h;
    assign w_byte   = w_word_b[7:0];
    assign w_half   = w_word_h[15:0];

    always_comb begin
        o_load  = i_word;
        o_store = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_load  = {{24{~i_unsigned & w_byte[7]}}, w_byte};
                o_store = (i_word & ~(32'h0000_00FF << w_sh_b))
                        | ({24'h0, i_wdata[7:0]} << w_sh_b);
            end
            SZ_HALF: begin
                o_load  = {{16{~i_unsigned & w_half[15]}}, w_half};
                o_store = (i_word & ~(32'h0000_FFFF << w_sh_h))
                        | ({16'h0, i_wdata[15:0]} << w_sh_h);
            end
            default: begin
                o_load  = i_word;
                o_store = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/unidade_load_store.sv
// Load/store unit: converts byte-addressed MIPS loads/stores into accesses
// on a word-indexed data memory. Sub-word stores are read-modify-write.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   req_valid/ready   : request handshake (ready only in IDLE)
//   req_we            : 1 = store, 0 = load
//   req_size          : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      : zero-extend loads when 1
//   req_addr          : byte address
//   req_wdata         : right-aligned store data
//   resp_valid        : one-cycle completion pulse
//   resp_rdata        : extended load data (0 for stores/faults)
//   resp_fault        : misaligned / illegal size / out of range
//   mem_we, mem_addr,
//   mem_wdata         : to the memory (mem_addr is a word index)
//   mem_rdata         : from the memory, valid the posedge after mem_addr
module unidade_load_store
    import pkg_lsu::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        r_state;
    lsu_state_t        w_next;

    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [1:0]        r_off;
    logic [31:0]       r_wdata;
    logic              r_fault;
    logic [31:0]       r_resp_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic              w_accept;
    logic [ADDR_W-1:0] w_word_idx;
    logic              w_fault;
    logic              w_word_store;
    logic [31:0]       w_load;
    logic [31:0]       w_store;

    assign w_accept     = req_valid && (r_state == IDLE);
    assign w_word_idx   = req_addr >> 2;
    assign w_word_store = req_we && (req_size == SZ_WORD);

    always_comb begin
        w_fault = 1'b0;
        if (req_size == SZ_ILLEGAL)                        w_fault = 1'b1;
        if ((req_size == SZ_HALF) && req_addr[0])          w_fault = 1'b1;
        if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) w_fault = 1'b1;
        if (w_word_idx >= ADDR_W'(MEM_WORDS))              w_fault = 1'b1;
    end

    lsu_alinhador_bytes u_alinhador (
        .i_word     (mem_rdata),
        .i_offset   (r_off),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_store    (w_store)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_fault)           w_next = RESP;
                    else if (w_word_store) w_next = WR;
                    else                   w_next = RD;
                end
            end
            RD:      w_next = r_we ? WR : RESP;   // sub-word stores continue to write-back
            WR:      w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request fields: only consumed in RD, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_off      <= req_addr[1:0];
            r_wdata    <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fault      <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'h0;
        end else if (w_accept) begin
            r_fault      <= w_fault;
            r_resp_rdata <= 32'h0;
            r_mem_addr   <= w_word_idx;
            if (!w_fault && w_word_store) r_mem_wdata <= req_wdata;
        end else if (r_state == RD) begin
            if (r_we) r_mem_wdata  <= w_store;
            else      r_resp_rdata <= w_load;
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_fault = (r_state == RESP) && r_fault;
    assign mem_we     = (r_state == WR);
    assign resp_rdata = r_resp_rdata;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule
